pmodjstk_spi_responder: RTL and testbench
=========================================

Name: pmodjstk_spi_responder

Overview:
- SPI slave that emulates the PmodJSTK joystick module. It answers the SPI master already in the design.
- Used for simulation and board loopback: the joystick interface is driven from internal position/button registers instead of the physical Pmod.
- Receives the 5-byte command frame on MOSI and returns X, Y and button data on MISO in PmodJSTK byte order.
- All logic runs in the system clock domain; SPI pins are oversampled.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers for SS, SCLK and MOSI.
- FRAME_BYTES, 5, bytes per frame.
- CMD_PREFIX, 6'b100000, required upper six bits of command byte 0.

Ports:
- CLK  in  1  system clock, 100 MHz, must be ≥ 8× SCLK.
- RST  in  1  synchronous, active-low reset.
- SS  in  1  slave select from master, active low.
- SCLK  in  1  serial clock from master, SPI mode 0.
- MOSI  in  1  master out slave in.
- MISO  out  1  slave out master in.
- x_pos  in  10  X position to report.
- y_pos  in  10  Y position to report.
- btn  in  3  button states {btn2, btn1, btn0}.
- led_cmd  out  2  LED bits from the last valid command byte, {LED2, LED1} = cmd[1:0].
- cmd_valid  out  1  one-CLK pulse when led_cmd updates.
- frame_done  out  1  one-CLK pulse on a correctly sized frame.
- frame_err  out  1  one-CLK pulse on a short or long frame.

Behaviour:
- Reset (RST=0 at a CLK rising edge):
  - Outputs: MISO=0, led_cmd=2'b00, cmd_valid=0, frame_done=0, frame_err=0.
  - FSM goes to IDLE; bit and byte counters clear.
  - Synchroniser reset values: SS=1, SCLK=0, MOSI=0.
- Edge detection: SS, SCLK and MOSI pass through the SYNC_STAGES synchronisers; edges are detected from the synchronised SS and SCLK.
- FSM states IDLE, LOAD, SHIFT, CHECK:
  - IDLE → LOAD on a synchronised SS falling edge.
  - LOAD, one cycle:
    - Snapshot x_pos, y_pos and btn into the 40-bit tx frame: byte0=x[7:0], byte1={6'b0,x[9:8]}, byte2=y[7:0], byte3={6'b0,y[9:8]}, byte4={5'b0,btn}.
    - Drive MISO with bit 7 of byte0 and clear the counters.
    - → SHIFT.
  - SHIFT:
    - SCLK rising: sample MOSI into the rx shift register, MSB first, and increment the bit count.
    - SCLK falling: present the next tx bit on MISO. After bit 40, MISO=0.
    - SS rising → CHECK.
  - CHECK, one cycle:
    - If bit count == 40: pulse frame_done. Additionally, if rx byte0[7:2] == CMD_PREFIX, load led_cmd ← rx byte0[1:0] and pulse cmd_valid in the same cycle.
    - If bit count != 40: pulse frame_err only; led_cmd holds.
    - → IDLE.
- MISO is 0 in IDLE.
- Latency: MISO holds its valid bit at least SYNC_STAGES+1 CLK cycles after the SCLK falling edge and before the next SCLK rising edge. This is guaranteed by the ≥8× oversampling rule.
- Bit counter saturates at 63. It never wraps, so any over-length frame reports frame_err.
- Simultaneous SCLK edge and SS rising edge in the same cycle: SS wins and the SCLK edge is ignored.
- Snapshot: changes to x_pos, y_pos or btn during SHIFT do not affect the frame in flight.
- Reset mid-frame: FSM goes to IDLE. If SS is still low at reset release, the remainder of that frame is ignored; a new SS falling edge is required to start a frame.
- Zero-bit frame (SS low then high with no SCLK): frame_err.

Optional Feature:
- JSTK_RESP_MISO_HIZ_EN
  - Defined: MISO is driven 1'bz whenever synchronised SS is high or the FSM is IDLE, so several responders can share one MISO line.
  - Undefined: MISO drives 0 in those cases.
  - All other behaviour is identical.

Decomposition:
- Package jstk_pkg holds:
  - the FSM state enum;
  - FRAME_BYTES, FRAME_BITS=40, CMD_PREFIX;
  - byte index constants (X_LO=0, X_HI=1, Y_LO=2, Y_HI=3, BTN=4).
- Sub-module spi_sync_edge: an N-stage synchroniser with rise/fall pulse outputs, instantiated for SS, SCLK and MOSI. The MOSI instance uses only its level output.

Test Plan:
- Nominal frame: x_pos=10'h2A5, y_pos=10'h13C, btn=3'b101; master sends 8'h83 then 4×8'h00 at 1 MHz SCLK.
  → MISO bytes A5,02,3C,01,05; led_cmd=2'b11; one cmd_valid and one frame_done pulse; no frame_err.
- Bad prefix: command byte 8'h41 in a full 40-bit frame.
  → frame_done pulses; cmd_valid stays 0; led_cmd keeps its previous value of 2'b11.
- Short frame: SS rises after 20 bits.
  → frame_err pulse only; led_cmd unchanged; FSM back to IDLE within 2 CLK; the next full frame succeeds.
- Snapshot: set x_pos=10'h3FF at SS fall, change it to 10'h000 after bit 3.
  → MISO returns FF,03 for the X bytes.
- Long frame: 48 bits.
  → bits 41–48 read 0 on MISO; frame_err pulses; no frame_done.
- Reset mid-frame: assert RST=0 for 2 cycles at bit 17 while SS stays low.
  → all outputs go to their reset values; the rest of that frame produces no pulses; the next SS-framed transfer completes normally.

Source files
------------

// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK SPI responder.
// Frame layout follows PmodJSTK byte order: X low, X high, Y low, Y high, buttons.
package jstk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        CHECK
    } state_t;

    localparam int         FRAME_BYTES = 5;
    localparam int         FRAME_BITS  = 40;
    localparam logic [5:0] CMD_PREFIX  = 6'b100000;

    localparam int X_LO = 0;
    localparam int X_HI = 1;
    localparam int Y_LO = 2;
    localparam int Y_HI = 3;
    localparam int BTN  = 4;

    // Byte 0 occupies the top bits so the frame shifts out MSB first.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] b
    );
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[FRAME_BITS-1-8*X_LO -: 8] = x[7:0];
        f[FRAME_BITS-1-8*X_HI -: 8] = {6'b0, x[9:8]};
        f[FRAME_BITS-1-8*Y_LO -: 8] = y[7:0];
        f[FRAME_BITS-1-8*Y_HI -: 8] = {6'b0, y[9:8]};
        f[FRAME_BITS-1-8*BTN  -: 8] = {5'b0, b};
        return f;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser with rise/fall pulses for one SPI pin.
// Edge pulses stay quiet until the chain has flushed after reset, so a pin held low is not seen as an edge.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic [STAGES:0]   r_vld;

    // NOTE: all state here uses non-blocking assignments so every stage samples the previous stage's old value.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
            r_vld  <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
            r_vld  <= {r_vld[STAGES-1:0], 1'b1};
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_vld[STAGES] &  o_level & ~r_prev;
    assign o_fall  = r_vld[STAGES] & ~o_level &  r_prev;

endmodule

// File: rtl/pmodjstk_spi_responder.sv
// SPI mode-0 slave emulating the PmodJSTK: returns X/Y/buttons, captures the LED command byte.
// Optional macro JSTK_RESP_MISO_HIZ_EN releases MISO (1'bz) while deselected or idle.
module pmodjstk_spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter int         FRAME_BYTES = jstk_pkg::FRAME_BYTES,
    parameter logic [5:0] CMD_PREFIX  = jstk_pkg::CMD_PREFIX
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] btn,
    output logic [1:0] led_cmd,
    output logic       cmd_valid,
    output logic       frame_done,
    output logic       frame_err
);

    import jstk_pkg::*;

    localparam logic [5:0] FRAME_CNT = 6'(FRAME_BYTES * 8);

    logic w_ss_level, w_ss_rise, w_ss_fall;
    logic w_sclk_level_unused, w_sclk_rise, w_sclk_fall;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .CLK(CLK), .RST(RST), .i_d(SS),
        .o_level(w_ss_level), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .CLK(CLK), .RST(RST), .i_d(SCLK),
        .o_level(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .CLK(CLK), .RST(RST), .i_d(MOSI),
        .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
    );

    state_t                r_state;
    logic [FRAME_BITS-1:0] r_tx;
    logic [FRAME_BITS-1:0] r_rx;
    logic [5:0]            r_bit_cnt;
    logic                  r_miso;
    logic [1:0]            r_led;
    logic                  r_cmd_valid;
    logic                  r_done;
    logic                  r_err;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= IDLE;
            r_tx        <= '0;
            r_rx        <= '0;
            r_bit_cnt   <= '0;
            r_miso      <= 1'b0;
            r_led       <= 2'b00;
            r_cmd_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_miso <= 1'b0;
                    if (w_ss_fall) r_state <= LOAD;
                end
                LOAD: begin
                    r_tx      <= build_frame(x_pos, y_pos, btn);
                    r_miso    <= x_pos[7];
                    r_rx      <= '0;
                    r_bit_cnt <= '0;
                    r_state   <= SHIFT;
                end
                SHIFT: begin
                    // Deselect has priority over a coincident SCLK edge.
                    if (w_ss_rise) begin
                        r_state <= CHECK;
                    end else if (w_sclk_rise) begin
                        r_rx <= {r_rx[FRAME_BITS-2:0], w_mosi};
                        if (r_bit_cnt != 6'h3F) r_bit_cnt <= r_bit_cnt + 6'd1;
                    end else if (w_sclk_fall) begin
                        r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
                        r_miso <= r_tx[FRAME_BITS-2];
                    end
                end
                CHECK: begin
                    r_miso  <= 1'b0;
                    r_state <= IDLE;
                    if (r_bit_cnt == FRAME_CNT) begin
                        r_done <= 1'b1;
                        if (r_rx[FRAME_BITS-1 -: 6] == CMD_PREFIX) begin
                            r_led       <= r_rx[FRAME_BITS-7 -: 2];
                            r_cmd_valid <= 1'b1;
                        end
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef JSTK_RESP_MISO_HIZ_EN
    assign MISO = (w_ss_level || r_state == IDLE) ? 1'bz : r_miso;
`else
    assign MISO = r_miso & ~w_ss_level;
`endif

    assign led_cmd    = r_led;
    assign cmd_valid  = r_cmd_valid;
    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule

// File: tb/tb_pmodjstk_spi_responder.sv
// Self-checking bench: a mode-0 SPI master at 1 MHz SCLK drives frames; MISO bytes and
// frame outcomes are scoreboarded against values derived from the PmodJSTK frame format.
module tb_pmodjstk_spi_responder;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SS = 1'b1;
    logic       SCLK = 1'b0;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] x_pos = '0;
    logic [9:0] y_pos = '0;
    logic [2:0] btn = '0;
    logic [1:0] led_cmd;
    logic       cmd_valid, frame_done, frame_err;

    pmodjstk_spi_responder dut (
        .CLK(CLK), .RST(RST), .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .x_pos(x_pos), .y_pos(y_pos), .btn(btn),
        .led_cmd(led_cmd), .cmd_valid(cmd_valid),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] b;
        logic [7:0] cmd;
        int         nbits;
        int         exp_done;
        int         exp_err;
        int         exp_cv;
        logic [1:0] exp_led;
    } vec_t;

    typedef struct {
        int         done;
        int         err;
        int         cv;
        logic [1:0] led;
    } outcome_t;

    logic [7:0] miso_q[$];
    outcome_t   out_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_cv   = 0;
    int cnt_done = 0;
    int cnt_err  = 0;

    always @(negedge CLK) begin
        if (RST) begin
            if (cmd_valid)  cnt_cv++;
            if (frame_done) cnt_done++;
            if (frame_err)  cnt_err++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [9:0] x, input logic [9:0] y,
                                            input logic [2:0] b, input int k);
        case (k)
            0:       return x[7:0];
            1:       return {6'b0, x[9:8]};
            2:       return y[7:0];
            3:       return {6'b0, y[9:8]};
            4:       return {5'b0, b};
            default: return 8'h00;
        endcase
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s MISO", tag), 64'(MISO), 64'd0);
        check($sformatf("%s led_cmd", tag), 64'(led_cmd), 64'd0);
        check($sformatf("%s cmd_valid", tag), 64'(cmd_valid), 64'd0);
        check($sformatf("%s frame_done", tag), 64'(frame_done), 64'd0);
        check($sformatf("%s frame_err", tag), 64'(frame_err), 64'd0);
    endtask

    // chg_bit >= 0 changes x_pos before that bit; rst_bit >= 0 pulses RST low for 2 CLK after that bit's rising edge.
    task automatic run_frame(input vec_t v, input int chg_bit, input logic [9:0] chg_x,
                             input int rst_bit, input string tag);
        logic [47:0] mf;
        logic [63:0] rx;
        logic [7:0]  act;
        outcome_t    o;
        int          dv, de, dc, nb;
        mf = {v.cmd, 40'h0};
        rx = '0;
        x_pos = v.x;
        y_pos = v.y;
        btn   = v.b;
        nb = (rst_bit < 0) ? v.nbits / 8 : 0;
        for (int k = 0; k < nb; k++) miso_q.push_back(exp_byte(v.x, v.y, v.b, k));
        o.done = v.exp_done;
        o.err  = v.exp_err;
        o.cv   = v.exp_cv;
        o.led  = v.exp_led;
        out_q.push_back(o);
        dv = cnt_done;
        de = cnt_err;
        dc = cnt_cv;

        SS = 1'b0;
        MOSI = mf[47];
        wait_clks(50);
        for (int i = 0; i < v.nbits; i++) begin
            if (i == chg_bit) x_pos = chg_x;
            rx = {rx[62:0], MISO};
            SCLK = 1'b1;
            if (i == rst_bit) begin
                RST = 1'b0;
                wait_clks(2);
                check_reset_outputs({tag, " in reset"});
                RST = 1'b1;
                wait_clks(48);
            end else begin
                wait_clks(50);
            end
            SCLK = 1'b0;
            MOSI = (i < 47) ? mf[46-i] : 1'b0;
            wait_clks(50);
        end
        SS = 1'b1;
        wait_clks(12);

        for (int k = 0; k < nb; k++) begin
            act = 8'(rx >> (v.nbits - 8 - 8 * k));
            check($sformatf("%s miso byte %0d", tag, k), 64'(act), 64'(miso_q.pop_front()));
        end
        o = out_q.pop_front();
        check($sformatf("%s frame_done count", tag), 64'(cnt_done - dv), 64'(o.done));
        check($sformatf("%s frame_err count", tag), 64'(cnt_err - de), 64'(o.err));
        check($sformatf("%s cmd_valid count", tag), 64'(cnt_cv - dc), 64'(o.cv));
        check($sformatf("%s led_cmd", tag), 64'(led_cmd), 64'(o.led));
        check($sformatf("%s MISO idle", tag), 64'(MISO), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl[6];
    vec_t v;

    initial begin
        tbl[0] = '{10'h2A5, 10'h13C, 3'b101, 8'h83, 40, 1, 0, 1, 2'b11};  // nominal
        tbl[1] = '{10'h155, 10'h0AA, 3'b010, 8'h41, 40, 1, 0, 0, 2'b11};  // bad prefix
        tbl[2] = '{10'h0F0, 10'h30F, 3'b001, 8'h80, 20, 0, 1, 0, 2'b11};  // short
        tbl[3] = '{10'h000, 10'h3FF, 3'b111, 8'h82, 40, 1, 0, 1, 2'b10};  // recovery
        tbl[4] = '{10'h1C3, 10'h24E, 3'b011, 8'h81, 48, 0, 1, 0, 2'b10};  // long
        tbl[5] = '{10'h111, 10'h222, 3'b100, 8'h80,  0, 0, 1, 0, 2'b10};  // zero-bit

        RST = 1'b0;
        wait_clks(3);
        check_reset_outputs("reset");
        RST = 1'b1;
        wait_clks(5);

        for (int i = 0; i < 6; i++) run_frame(tbl[i], -1, 10'h000, -1, $sformatf("vec%0d", i));

        // X bytes must come from the snapshot taken at SS fall.
        v = '{10'h3FF, 10'h155, 3'b110, 8'h81, 40, 1, 0, 1, 2'b01};
        run_frame(v, 3, 10'h000, -1, "snapshot");

        v = '{10'h2A5, 10'h13C, 3'b101, 8'h82, 40, 0, 0, 0, 2'b00};
        run_frame(v, -1, 10'h000, 17, "rst_mid");

        v = '{10'h2A5, 10'h13C, 3'b101, 8'h83, 40, 1, 0, 1, 2'b11};
        run_frame(v, -1, 10'h000, -1, "post_rst");

        check("scoreboard miso empty", 64'(miso_q.size()), 64'd0);
        check("scoreboard outcome empty", 64'(out_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
